// File: rtl/dispensador_ctrl_if.sv
// Request/drive bundle between the vending core and dispensador_ctrl.
// Optional macro DISP_SENSOR_EN adds the product-drop sensor input and the fault flag.
interface dispensador_ctrl_if;
   logic       vendA;
   logic       vendB;
   logic [3:0] cambio;
   logic       motorA;
   logic       motorB;
   logic       coin_big;
   logic       coin_small;
   logic       busy;
   logic       done;
   logic       overrun;
`ifdef DISP_SENSOR_EN
   logic       producto_ok;
   logic       fault;
`endif

   modport master (
      output vendA, vendB, cambio,
      input  motorA, motorB, coin_big, coin_small, busy, done, overrun
`ifdef DISP_SENSOR_EN
      , output producto_ok
      , input  fault
`endif
   );

   modport slave (
      input  vendA, vendB, cambio,
      output motorA, motorB, coin_big, coin_small, busy, done, overrun
`ifdef DISP_SENSOR_EN
      , input  producto_ok
      , output fault
`endif
   );
endinterface

// File: rtl/dispensador_ctrl.sv
// Vend sequencer: runs the product motor, pays change (large coins first)
// and reports busy/done/overrun. One request can wait in the pending slot.
// Optional macro DISP_SENSOR_EN: DISPENSE ends on producto_ok, MOTOR_CYC
// becomes a timeout that skips change and sets the sticky fault output.
//
// state    | meaning
// IDLE     | waiting; a captured request starts DISPENSE on the next edge
// DISPENSE | selected motor running
// CHANGE   | one coin pulse this cycle
// GAP      | quiet cycles between coin pulses
// DONE     | single cycle with done=1
module dispensador_ctrl #(
   parameter int MOTOR_CYC = 8,
   parameter int COIN_GAP  = 2,
   parameter int BIG_VAL   = 2
) (
   input logic               clk,
   input logic               reset,
   dispensador_ctrl_if.slave bus
);
   localparam int            CW         = $clog2(MOTOR_CYC + COIN_GAP + 2);
   localparam logic [CW-1:0] MOTOR_LOAD = CW'(MOTOR_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD   = (COIN_GAP > 0) ? CW'(COIN_GAP - 1) : '0;
   localparam logic [3:0]    BIG_V      = 4'(BIG_VAL);

   typedef enum logic [2:0] {S_IDLE, S_DISPENSE, S_CHANGE, S_GAP, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    big_q, big_d;
   logic [3:0]    small_q, small_d;
   logic          sel_b_q, sel_b_d;
   logic          pend_vld_q, pend_vld_d;
   logic          pend_b_q, pend_b_d;
   logic [3:0]    pend_cambio_q, pend_cambio_d;
   logic [4:0]    coins_left;
   logic          take_pend;
   logic          ov_set;

   logic motor_a_q, motor_a_d;
   logic motor_b_q, motor_b_d;
   logic coin_big_q, coin_big_d;
   logic coin_small_q, coin_small_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic overrun_q, overrun_d;
`ifdef DISP_SENSOR_EN
   logic flt_set;
   logic fault_q, fault_d;
`endif

   assign coins_left = {1'b0, big_q} + {1'b0, small_q};

   // State, timer, change counters and pending slot
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         big_q         <= '0;
         small_q       <= '0;
         sel_b_q       <= 1'b0;
         pend_vld_q    <= 1'b0;
         pend_b_q      <= 1'b0;
         pend_cambio_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         big_q         <= big_d;
         small_q       <= small_d;
         sel_b_q       <= sel_b_d;
         pend_vld_q    <= pend_vld_d;
         pend_b_q      <= pend_b_d;
         pend_cambio_q <= pend_cambio_d;
      end
   end

   // Next state; every request (even from IDLE) passes through the pending slot
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      big_d         = big_q;
      small_d       = small_q;
      sel_b_d       = sel_b_q;
      pend_vld_d    = pend_vld_q;
      pend_b_d      = pend_b_q;
      pend_cambio_d = pend_cambio_q;
      take_pend     = 1'b0;
      ov_set        = 1'b0;
`ifdef DISP_SENSOR_EN
      flt_set       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pend_vld_q) take_pend = 1'b1;
         end
         S_DISPENSE: begin
`ifdef DISP_SENSOR_EN
            if (bus.producto_ok) begin
               state_d = (coins_left == '0) ? S_DONE : S_CHANGE;
            end else if (cnt_q == '0) begin
               state_d = S_DONE;
               flt_set = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
`else
            if (cnt_q == '0) state_d = (coins_left == '0) ? S_DONE : S_CHANGE;
            else             cnt_d   = cnt_q - CW'(1);
`endif
         end
         S_CHANGE: begin
            if (big_q != '0) big_d   = big_q - 4'd1;
            else             small_d = small_q - 4'd1;
            if (coins_left == 5'd1) begin
               state_d = S_DONE;
            end else if (COIN_GAP == 0) begin
               state_d = S_CHANGE;
            end else begin
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_CHANGE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_DONE: begin
            if (pend_vld_q) take_pend = 1'b1;
            else            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (take_pend) begin
         state_d    = S_DISPENSE;
         cnt_d      = MOTOR_LOAD;
         sel_b_d    = pend_b_q;
         big_d      = pend_cambio_q / BIG_V;
         small_d    = pend_cambio_q % BIG_V;
         pend_vld_d = 1'b0;
      end

      // A pulse arriving while the slot is occupied is lost, even if the slot
      // is being consumed on this same edge.
      if (bus.vendA || bus.vendB) begin
         if (pend_vld_q) begin
            ov_set = 1'b1;
         end else begin
            pend_vld_d    = 1'b1;
            pend_b_d      = !bus.vendA;
            pend_cambio_d = bus.cambio;
            ov_set        = bus.vendA && bus.vendB;
         end
      end
   end

   // Output decode from the next state so registered outputs line up with state_q
   always_comb begin
      motor_a_d    = (state_d == S_DISPENSE) && !sel_b_d;
      motor_b_d    = (state_d == S_DISPENSE) &&  sel_b_d;
      coin_big_d   = (state_d == S_CHANGE) && (big_d != '0);
      coin_small_d = (state_d == S_CHANGE) && (big_d == '0);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      overrun_d    = overrun_q | ov_set;
`ifdef DISP_SENSOR_EN
      fault_d      = fault_q | flt_set;
`endif
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         motor_a_q    <= 1'b0;
         motor_b_q    <= 1'b0;
         coin_big_q   <= 1'b0;
         coin_small_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef DISP_SENSOR_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         motor_a_q    <= motor_a_d;
         motor_b_q    <= motor_b_d;
         coin_big_q   <= coin_big_d;
         coin_small_q <= coin_small_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
`ifdef DISP_SENSOR_EN
         fault_q      <= fault_d;
`endif
      end
   end

   assign bus.motorA     = motor_a_q;
   assign bus.motorB     = motor_b_q;
   assign bus.coin_big   = coin_big_q;
   assign bus.coin_small = coin_small_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.overrun    = overrun_q;
`ifdef DISP_SENSOR_EN
   assign bus.fault      = fault_q;
`endif
endmodule
